// File: rtl/ascon_pack.sv
// Shared Ascon permutation definitions: state type, S-box, rotation amounts,
// round constants and the iterator FSM encoding.
package ascon_pack;

    localparam int ROUND_NB = 12;
    localparam int WORD_W   = 64;
    localparam int WORD_NB  = 5;

    // Word 0 (x0) is the most significant 64 bits of the packed state.
    typedef logic [0:WORD_NB-1][WORD_W-1:0] type_state;
    typedef logic [3:0]                     type_round;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } type_fsm;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
        5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
        5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
        5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
    };

    localparam int unsigned ROT_A [WORD_NB] = '{19, 61, 1, 10, 7};
    localparam int unsigned ROT_B [WORD_NB] = '{28, 39, 6, 17, 41};

    function automatic logic [7:0] round_const(input type_round r);
        return {4'hF - r, r};
    endfunction

    function automatic logic [WORD_W-1:0] ror64(input logic [WORD_W-1:0] x,
                                                input int unsigned     n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, S-box layer, linear layer.
module ascon_round
    import ascon_pack::*;
(
    input  type_state state_i,
    input  type_round round_i,
    output type_state state_o
);

    type_state  pc_s;
    type_state  ps_s;
    logic [4:0] col;
    logic [4:0] sub;

    always_comb begin
        pc_s    = state_i;
        pc_s[2] = state_i[2] ^ {56'b0, round_const(round_i)};
    end

    // Each bit column across the five words is one S-box lookup, x0 as MSB.
    always_comb begin
        ps_s = '0;
        col  = '0;
        sub  = '0;
        for (int j = 0; j < WORD_W; j++) begin
            col = {pc_s[0][j], pc_s[1][j], pc_s[2][j], pc_s[3][j], pc_s[4][j]};
            sub = SBOX[col];
            for (int w = 0; w < WORD_NB; w++) begin
                ps_s[w][j] = sub[4-w];
            end
        end
    end

    always_comb begin
        state_o = '0;
        for (int w = 0; w < WORD_NB; w++) begin
            state_o[w] = ps_s[w] ^ ror64(ps_s[w], ROT_A[w]) ^ ror64(ps_s[w], ROT_B[w]);
        end
    end

endmodule

// File: rtl/permutation_iter.sv
// Iterative Ascon permutation: one round per clock on a registered 320-bit
// state; the first round index selects p12 / p8 / p6.
module permutation_iter
    import ascon_pack::*;
(
    input  logic      clock_i,
    input  logic      resetb_i,
    input  logic      start_i,
    input  logic [3:0] round_start_i,
    input  type_state state_i,
    output type_state state_o,
    output logic      busy_o,
    output logic      done_o
);

    type_fsm   fsm_q, fsm_d;
    type_state state_q, state_d;
    type_round cnt_q, cnt_d;

    type_state round_in;
    type_state round_out;
    type_round round_idx;

    ascon_round u_round (
        .state_i (round_in),
        .round_i (round_idx),
        .state_o (round_out)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        fsm_d     = fsm_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        round_in  = state_q;
        round_idx = cnt_q;

        unique case (fsm_q)
            ST_IDLE: begin
                if (start_i) begin
                    round_in  = state_i;
                    round_idx = round_start_i;
                    if (round_start_i > 4'(ROUND_NB - 1)) begin
                        // Out-of-range index: zero rounds, hand the input straight back.
                        state_d = state_i;
                        fsm_d   = ST_DONE;
                    end else begin
                        state_d = round_out;
                        cnt_d   = round_start_i + 4'd1;
                        fsm_d   = (round_start_i == 4'(ROUND_NB - 1)) ? ST_DONE : ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                state_d = round_out;
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'(ROUND_NB - 1)) begin
                    fsm_d = ST_DONE;
                end
            end
            ST_DONE: begin
                fsm_d = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking so all registers update from the same pre-edge values.
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;
    assign busy_o  = (fsm_q != ST_IDLE);
    assign done_o  = (fsm_q == ST_DONE);

endmodule

// File: tb/tb_permutation_iter.sv
// Self-checking bench for permutation_iter: a queue-based reference model of
// the Ascon permutation is compared against the DUT on every cycle.
module tb_permutation_iter;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [3:0]   rs;
    logic [319:0] st_in;
    logic [319:0] st_out;
    logic         busy;
    logic         done;

    int n_err    = 0;
    int n_checks = 0;
    bit chk_en   = 0;

    permutation_iter dut (
        .clock_i       (clk),
        .resetb_i      (rst_n),
        .start_i       (start),
        .round_start_i (rs),
        .state_i       (st_in),
        .state_o       (st_out),
        .busy_o        (busy),
        .done_o        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Bitsliced S-box as written in the Ascon C reference.
    function automatic logic [319:0] ref_sbox(input logic [319:0] s);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x0 ^= x4; x4 ^= x3; x2 ^= x1;
        t0 = x0 ^ (~x1 & x2);
        t1 = x1 ^ (~x2 & x3);
        t2 = x2 ^ (~x3 & x4);
        t3 = x3 ^ (~x4 & x0);
        t4 = x4 ^ (~x0 & x1);
        t1 ^= t0; t0 ^= t4; t3 ^= t2; t2 = ~t2;
        return {t0, t1, t2, t3, t4};
    endfunction

    function automatic logic [319:0] ref_linear(input logic [319:0] s);
        logic [63:0] x0, x1, x2, x3, x4;
        {x0, x1, x2, x3, x4} = s;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic logic [319:0] ref_round(input logic [319:0] s, input int r);
        logic [319:0] t;
        t = s;
        t[191:128] = t[191:128] ^ 64'((15 - r) * 16 + r);
        return ref_linear(ref_sbox(t));
    endfunction

    typedef struct packed {
        logic [319:0] s;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t         cur = '0;
    exp_t         exp_q [$];
    logic [319:0] model_s;

    // On an accepted start, the whole future output sequence is queued.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur = '0;
            exp_q.delete();
        end else begin
            if (!cur.busy && start) begin
                if (rs > 4'd11) begin
                    exp_q.push_back(exp_t'{st_in, 1'b1, 1'b1});
                end else begin
                    model_s = st_in;
                    for (int r = int'(rs); r < 12; r++) begin
                        model_s = ref_round(model_s, r);
                        exp_q.push_back(exp_t'{model_s, 1'b1, (r == 11)});
                    end
                end
            end
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else                  cur = exp_t'{cur.s, 1'b0, 1'b0};
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("state_o", st_out, cur.s);
            check("busy_o",  {319'b0, busy}, {319'b0, cur.busy});
            check("done_o",  {319'b0, done}, {319'b0, cur.done});
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [319:0] rand320();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk); #1;
        end
    endtask

    // Pulses start and measures cycles from the accepting edge to done_o.
    // Inputs are scrambled during the run: they must have no effect.
    task automatic timed_run(input logic [3:0] rs_v, input logic [319:0] st_v,
                             input int exp_lat, input string name);
        int lat;
        bit got;
        lat = -1;
        got = 0;
        @(negedge clk); #1;
        start = 1'b1;
        rs    = rs_v;
        st_in = st_v;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                lat = i;
            end
            #1;
            start = 1'b0;
            rs    = 4'($urandom);
            st_in = rand320();
        end
        check_int(name, lat, exp_lat);
    endtask

    logic [4:0]   sbox_tab [32] = '{
        5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
        5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
        5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
        5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
    };

    logic [319:0] iv_state;
    logic [319:0] pin;
    logic [319:0] pout;
    logic [319:0] saved;
    logic [4:0]   v;
    logic [4:0]   col;
    int           done_pos [$];
    int           pulses;

    initial begin
        iv_state = {64'h80400C0600000000, 64'h0001020304050607, 64'h08090A0B0C0D0E0F,
                    64'h0001020304050607, 64'h08090A0B0C0D0E0F};

        // Reset with busy-looking inputs applied.
        rst_n = 1'b0;
        start = 1'b1;
        rs    = 4'd0;
        st_in = rand320();
        repeat (3) @(negedge clk);
        chk_en = 1;
        check("reset state_o", st_out, '0);
        check("reset busy_o",  {319'b0, busy}, '0);
        check("reset done_o",  {319'b0, done}, '0);
        #1;
        start = 1'b0;
        rst_n = 1'b1;
        idle_cycles(20);

        // Pin the model: S-box against the table, one round against a hand result.
        pin = '0;
        for (int j = 0; j < 32; j++) begin
            v = 5'(j);
            pin[256+j] = v[4]; pin[192+j] = v[3]; pin[128+j] = v[2];
            pin[64+j]  = v[1]; pin[j]     = v[0];
        end
        pout = ref_sbox(pin);
        for (int j = 0; j < 32; j++) begin
            col = {pout[256+j], pout[192+j], pout[128+j], pout[64+j], pout[j]};
            check($sformatf("model sbox[%0d]", j), {315'b0, col}, {315'b0, sbox_tab[j]});
        end
        check("model round0 of zero", ref_round('0, 0),
              {64'h001E0F00000000F0, 64'h00000001E0000770, 64'h3FFFFFFFFFFFFF74,
               64'h3C780000000000F0, 64'h0000000000000000});

        // p12 on the Ascon-128 initial state, then p8 / p6 / single round.
        timed_run(4'd0, iv_state, 12, "p12 latency");
        idle_cycles(2);
        for (int k = 0; k < 3; k++) begin
            timed_run(4'd4, rand320(), 8, "p8 latency");
            timed_run(4'd6, rand320(), 6, "p6 latency");
            timed_run(4'd11, rand320(), 1, "p1 latency");
            idle_cycles(1);
        end
        for (int k = 0; k < 4; k++) begin
            v = 5'($urandom_range(0, 11));
            timed_run(v[3:0], rand320(), 12 - int'(v), "random index latency");
        end

        // Illegal indices return the input untouched one cycle later.
        saved = rand320();
        timed_run(4'd13, saved, 1, "illegal 13 latency");
        check("illegal 13 state_o", st_out, saved);
        saved = rand320();
        timed_run(4'd15, saved, 1, "illegal 15 latency");
        check("illegal 15 state_o", st_out, saved);
        idle_cycles(2);

        // start held high: back-to-back p6 runs with one idle cycle between.
        done_pos.delete();
        @(negedge clk); #1;
        start = 1'b1;
        rs    = 4'd6;
        st_in = rand320();
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) done_pos.push_back(i);
            #1;
            st_in = rand320();
        end
        start = 1'b0;
        check_int("back-to-back pulse count", done_pos.size(), 5);
        for (int i = 1; i < done_pos.size(); i++) begin
            check_int("back-to-back period", done_pos[i] - done_pos[i-1], 7);
        end
        idle_cycles(8);

        // Reset in the middle of a p12 run.
        @(negedge clk); #1;
        start = 1'b1;
        rs    = 4'd0;
        st_in = rand320();
        repeat (5) begin
            @(negedge clk); #1;
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("mid-run reset state_o", st_out, '0);
        check("mid-run reset busy_o",  {319'b0, busy}, '0);
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) pulses++;
        end
        #1;
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check_int("no done after reset", pulses, 0);
        timed_run(4'd0, iv_state, 12, "p12 after reset latency");
        idle_cycles(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
